// File: rtl/gpr_multiport.sv
// Multi-port general-purpose register file: DEPTH x DW storage, NR registered read ports, NW write ports.
// Optional write-through read bypass is enabled by defining GPR_BYPASS_EN; the default build reads pre-write contents.
module gpr_multiport #(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int NR       = 2,
  parameter int NW       = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NR-1:0]     ren,
  input  logic [NR*AW-1:0]  raddr,
  output logic [NR*DW-1:0]  rdata,
  input  logic [NW-1:0]     we,
  input  logic [NW*AW-1:0]  waddr,
  input  logic [NW*DW-1:0]  wdata
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_L);
  endfunction

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == {AW{1'b0}});
  endfunction

  logic [DW-1:0]    mem_r [DEPTH];
  logic [NW-1:0]    wr_ok_s;
  logic [NR*DW-1:0] rd_next_s;
  logic [NR*DW-1:0] rdata_r;

  // Qualify each write port: enabled, in range and not aimed at a hardwired zero entry.
  always_comb begin
    wr_ok_s = {NW{1'b0}};
    for (int j = 0; j < NW; j++) begin
      wr_ok_s[j] = we[j] && in_range(waddr[j*AW +: AW]) && !is_zero_reg(waddr[j*AW +: AW]);
    end
  end

  // Next read data per port: hold, force to zero, or load storage (optionally bypassed from a write).
  always_comb begin
    rd_next_s = rdata_r;
    for (int i = 0; i < NR; i++) begin
      if (!ren[i]) begin
        rd_next_s[i*DW +: DW] = rdata_r[i*DW +: DW];
      end else if (!in_range(raddr[i*AW +: AW]) || is_zero_reg(raddr[i*AW +: AW])) begin
        rd_next_s[i*DW +: DW] = {DW{1'b0}};
      end else begin
        rd_next_s[i*DW +: DW] = mem_r[raddr[i*AW +: AW]];
`ifdef GPR_BYPASS_EN
        // Ascending scan so the highest-index matching write port wins, same as storage.
        for (int j = 0; j < NW; j++) begin
          if (wr_ok_s[j] && (waddr[j*AW +: AW] == raddr[i*AW +: AW])) begin
            rd_next_s[i*DW +: DW] = wdata[j*DW +: DW];
          end else begin
            rd_next_s[i*DW +: DW] = rd_next_s[i*DW +: DW];
          end
        end
`endif
      end
    end
  end

  // Storage update; later loop iterations override earlier ones, giving highest-index priority.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem_r[e] <= {DW{1'b0}};
      end
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (wr_ok_s[j]) begin
          mem_r[waddr[j*AW +: AW]] <= wdata[j*DW +: DW];
        end
      end
    end
  end

  // Registered read data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_r <= {(NR*DW){1'b0}};
    end else begin
      rdata_r <= rd_next_s;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: doc/gpr_multiport.md
Name: gpr_multiport

Overview:
Parametrised general-purpose register file for the datapath: DEPTH entries of DW bits, NR independent registered read ports and NW write ports.
Generalises the single-write, two-read register file with:
- configurable width, depth and port counts
- per-port read enables (hold on stall)
- deterministic multi-write priority
- optional write-to-read bypass
Sits between decode (read addresses) and writeback (write ports); read data is valid one cycle after the address.

Parameters:
DW, 32, data width in bits
DEPTH, 32, number of register entries (>=2, need not be a power of two)
AW, $clog2(DEPTH), address width
NR, 2, number of read ports (1..4)
NW, 1, number of write ports (1..2)
ZERO_REG, 1, 1 = entry 0 reads as zero and ignores writes; 0 = entry 0 is an ordinary register

Ports:
clk  input  1  clock, all state updates on rising edge
rstn  input  1  reset, asynchronous, active-low
ren  input  NR  per-read-port enable; bit i belongs to port i
raddr  input  NR*AW  read addresses; port i at bits [i*AW +: AW]
rdata  output  NR*DW  registered read data; port i at bits [i*DW +: DW]
we  input  NW  per-write-port enable
waddr  input  NW*AW  write addresses; port j at bits [j*AW +: AW]
wdata  input  NW*DW  write data; port j at bits [j*DW +: DW]

Behaviour:
- Reset: rstn low asynchronously clears all DEPTH entries and all rdata to 0. Entries and rdata stay 0 while rstn is low. The first update happens on the first rising clk after rstn deasserts.
- Write: at the rising edge, entry waddr[j] <= wdata[j] when all of these hold:
  - we[j]=1
  - waddr[j] < DEPTH
  - not (ZERO_REG=1 and waddr[j]=0)
  Out-of-range and suppressed writes are silently dropped.
- Write collision: when two write ports hit the same entry in one cycle, the highest-index port wins. No error is flagged.
- Read latency is 1 cycle. At the rising edge, for each port i with ren[i]=1, rdata[i] <= the value of entry raddr[i].
- Read hold: ren[i]=0 holds rdata[i] at its previous value, even if the entry it came from is overwritten.
- Read value forcing: rdata[i] loads 0 if raddr[i] >= DEPTH, or if ZERO_REG=1 and raddr[i]=0. This overrides the bypass.
- Same-cycle read/write to the same entry: governed by GPR_BYPASS_EN (see below).
- Read ports are independent. Any number of ports may read the same address in the same cycle with identical results.
- No combinational path from any input to rdata.

Optional Feature:
Macro GPR_BYPASS_EN.
- Defined (write-through): when ren[i]=1 and a qualifying write targets raddr[i] in the same cycle, rdata[i] loads that write's wdata. With multiple qualifying writes, the highest-index write port wins, matching the storage result. Read-after-write in the next cycle therefore needs no forwarding.
- Undefined (read-before-write): rdata[i] loads the entry's pre-write contents. The new value is visible to reads issued from the next cycle on. This matches the existing register file's timing.
- Both modes keep the zero-register and out-of-range forcing rules.

Test Plan:
1. Reset: preload entries 1..31 with 0xFFFF_FFFF, pulse rstn low between clock edges -> all rdata drop to 0 immediately (before the next edge). A subsequent read of entries 1..31 returns 0x0000_0000.
2. Basic write/read (NR=2, NW=1): write 0xDEAD_BEEF to entry 5. Next cycle, raddr0=5, raddr1=5, ren=2'b11 -> one edge later both rdata = 0xDEAD_BEEF.
3. Zero register: write 0x1234_5678 to entry 0 with ZERO_REG=1 -> read of entry 0 returns 0. Repeat with ZERO_REG=0 -> read returns 0x1234_5678.
4. Same-cycle read/write: entry 7 holds 0x1, write 0x2 to entry 7 while reading entry 7:
   - with GPR_BYPASS_EN defined -> rdata = 0x2
   - without it -> rdata = 0x1, and the next-cycle read returns 0x2
5. Dual write collision (NW=2): we=2'b11, both waddr=9, wdata0=0xAAAA_0000, wdata1=0x0000_5555 -> entry 9 holds 0x0000_5555. A bypassed read of entry 9 in the same cycle also returns 0x0000_5555.
6. Stall and range (DEPTH=24): rdata0 = 0xCAFE from entry 3, then ren0=0 while entry 3 is overwritten with 0xBEEF -> rdata0 stays 0xCAFE. Separately, raddr=30 with ren=1 -> rdata=0, and a write to address 30 leaves all entries unchanged.
